// File: rtl/serial_add_scheduler.sv
// Purpose: shares one LSB-first serial adder among N_REQ requesters; SADD_RR_EN selects round-robin arbitration.
// Latency: grant in cycle t, W bit cycles t+1..t+W, rsp_vld from t+W+1 (plus one cycle per ser_hold cycle).
// Backpressure: ser_hold stalls bit issue; rsp_rdy low holds the result in DONE; no grant until the result is taken.
module serial_add_scheduler #(
   parameter int N_REQ = 2,
   parameter int W     = 8,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_vld,
   output logic [N_REQ-1:0]   req_rdy,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic               rsp_vld,
   input  logic               rsp_rdy,
   output logic [ID_W-1:0]    rsp_id,
   output logic [W-1:0]       rsp_sum,
   input  logic               ser_hold,
   output logic               ser_vld,
   output logic               ser_a,
   output logic               ser_b,
   output logic               ser_last,
   input  logic               ser_sum
);

   localparam int CNT_W = $clog2(W);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     op_a_q, op_b_q;
   logic [W-1:0]     acc_q, acc_d;
   logic [ID_W-1:0]  id_q;
   logic [ID_W-1:0]  gnt_id;
   logic             gnt_any;
   logic             grant;
   logic             last_bit;
   logic [W-1:0]     sel_a, sel_b;

   assign last_bit = (cnt_q == CNT_W'(W - 1));
   assign grant    = (state_q == IDLE) && gnt_any;

`ifdef SADD_RR_EN
   logic [ID_W-1:0] ptr_q;

   // Round-robin pick: search starts at the pointer and wraps.
   always_comb begin
      logic [ID_W-1:0] idx;
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'((int'(ptr_q) + k) % N_REQ);
         if (!gnt_any && req_vld[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   // Pointer moves past the requester just granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant) begin
         ptr_q <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end
`else
   // Fixed priority pick: lowest index wins.
   always_comb begin
      logic [ID_W-1:0] idx;
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'(k);
         if (!gnt_any && req_vld[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
   end
`endif

   // Operand mux for the granted requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_id == ID_W'(k)) begin
            sel_a = req_a[k*W +: W];
            sel_b = req_b[k*W +: W];
         end
      end
   end

   // Accumulator with the current sum bit merged in.
   always_comb begin
      acc_d        = acc_q;
      acc_d[cnt_q] = ser_sum;
   end

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and all handshake / serial pin outputs.
   always_comb begin
      state_d  = state_q;
      req_rdy  = '0;
      rsp_vld  = 1'b0;
      ser_vld  = 1'b0;
      ser_a    = 1'b0;
      ser_b    = 1'b0;
      ser_last = 1'b0;
      case (state_q)
         IDLE: begin
            // rst gate keeps req_rdy low while reset is held with requests pending.
            if (gnt_any && !rst) begin
               req_rdy[gnt_id] = 1'b1;
               state_d         = SHIFT;
            end
         end
         SHIFT: begin
            if (!ser_hold) begin
               ser_vld  = 1'b1;
               ser_a    = op_a_q[cnt_q];
               ser_b    = op_b_q[cnt_q];
               ser_last = last_bit;
               if (last_bit) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            rsp_vld = 1'b1;
            if (rsp_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latch at grant, bit capture while shifting, result publish on the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         acc_q   <= '0;
         id_q    <= '0;
         rsp_sum <= '0;
         rsp_id  <= '0;
      end else begin
         if (grant) begin
            op_a_q <= sel_a;
            op_b_q <= sel_b;
            id_q   <= gnt_id;
            cnt_q  <= '0;
         end
         if (ser_vld) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            // Result register only changes when a full word is in, so no partial sum is visible.
            if (last_bit) begin
               rsp_sum <= acc_d;
               rsp_id  <= id_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Bench for serial_add_scheduler with a behavioural LSB-first serial adder attached.
// Directed jobs: single add, overflow wrap, hold stall, contention with stalled consumer, mid-job reset.
// Build with SADD_RR_EN defined to check round-robin ordering.
module tb_serial_add_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_vld;
   logic [1:0]  req_rdy;
   logic [15:0] req_a, req_b;
   logic        rsp_vld, rsp_rdy;
   logic [0:0]  rsp_id;
   logic [7:0]  rsp_sum;
   logic        ser_hold, ser_vld, ser_a, ser_b, ser_last, ser_sum;
   logic        carry;

   int n_chk = 0;
   int n_err = 0;

   serial_add_scheduler #(.N_REQ(2), .W(8)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .ser_hold(ser_hold), .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b),
      .ser_last(ser_last), .ser_sum(ser_sum)
   );

   always #5 clk = ~clk;

   // External serial adder: sum is combinational, carry clears on last and on reset.
   assign ser_sum = ser_a ^ ser_b ^ carry;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) carry <= 1'b0;
      else if (ser_vld) carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (ser_a & carry) | (ser_b & carry));
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Runs one job from IDLE; returns at the first rsp_vld sample (lat = cycles after grant edge, 0 on timeout).
   task automatic job(input int r, input logic [7:0] a, input logic [7:0] b, input int hs,
                      output int lat, output int nv, output int lastc, output int hv, output int rx);
      lat = 0; nv = 0; lastc = 0; hv = 0; rx = 0;
      req_a[r*8 +: 8] = a;
      req_b[r*8 +: 8] = b;
      req_vld = '0;
      req_vld[r] = 1'b1;
      #1;
      chk("grant_rdy", {30'd0, req_rdy}, (r == 0) ? 32'h1 : 32'h2);
      @(posedge clk); #2;
      req_vld = '0;
      req_a = ~req_a;
      req_b = ~req_b;
      for (int c = 1; c <= 40; c++) begin
         ser_hold = (hs > 0) && (c >= hs) && (c < hs + 3);
         #1;
         if (rsp_vld) begin
            lat = c;
            break;
         end
         if (ser_vld) nv++;
         if (ser_last) lastc = c;
         if (ser_hold && ser_vld) hv++;
         if (req_rdy != 2'b00) rx++;
         @(posedge clk); #2;
      end
      ser_hold = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, nv, lastc, hv, rx, unstable, seen;
      logic [7:0] s0;
      logic [0:0] i0;

      rst = 1'b1; req_vld = '0; req_a = '0; req_b = '0; rsp_rdy = 1'b1; ser_hold = 1'b0;
      #1;
      chk("rst_rsp_vld", {31'd0, rsp_vld}, 0);
      chk("rst_ser_vld", {31'd0, ser_vld}, 0);
      chk("rst_rsp_sum", {24'd0, rsp_sum}, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;

      // Single job 35+4A with consumer always ready.
      job(0, 8'h35, 8'h4A, 0, lat, nv, lastc, hv, rx);
      chk("t1_latency", lat, 9);
      chk("t1_vld_cycles", nv, 8);
      chk("t1_last_cycle", lastc, 8);
      chk("t1_rdy_extra", rx, 0);
      chk("t1_sum", {24'd0, rsp_sum}, 32'h7F);
      chk("t1_id", {31'd0, rsp_id}, 0);
      @(posedge clk); #2;
      #1;
      chk("t1_bubble", {31'd0, rsp_vld}, 0);

      // Overflow wraps, then carry must be clear for the next job.
      job(0, 8'hFF, 8'h01, 0, lat, nv, lastc, hv, rx);
      chk("ovf_sum", {24'd0, rsp_sum}, 32'h00);
      @(posedge clk); #2;
      job(0, 8'h02, 8'h03, 0, lat, nv, lastc, hv, rx);
      chk("ovf_next_sum", {24'd0, rsp_sum}, 32'h05);
      @(posedge clk); #2;

      // Three-cycle hold in mid-shift, on requester 1.
      job(1, 8'h0F, 8'h01, 4, lat, nv, lastc, hv, rx);
      chk("hold_latency", lat, 12);
      chk("hold_vld_cycles", nv, 8);
      chk("hold_vld_during", hv, 0);
      chk("hold_last_cycle", lastc, 11);
      chk("hold_sum", {24'd0, rsp_sum}, 32'h10);
      chk("hold_id", {31'd0, rsp_id}, 1);
      @(posedge clk); #2;

      // Contention with a stalled consumer.
      rsp_rdy = 1'b0;
      req_a = {8'd2, 8'd1};
      req_b = {8'd2, 8'd1};
      req_vld = 2'b11;
      for (int j = 0; j < 4; j++) begin
         seen = 0;
         for (int c = 0; c < 40; c++) begin
            #1;
            if (rsp_vld) begin
               seen = 1;
               break;
            end
            @(posedge clk); #2;
         end
         chk($sformatf("cont%0d_seen", j), seen, 1);
`ifdef SADD_RR_EN
         chk($sformatf("cont%0d_id", j), {31'd0, rsp_id}, j % 2);
         chk($sformatf("cont%0d_sum", j), {24'd0, rsp_sum}, (j % 2 == 1) ? 4 : 2);
`else
         chk($sformatf("cont%0d_id", j), {31'd0, rsp_id}, 0);
         chk($sformatf("cont%0d_sum", j), {24'd0, rsp_sum}, 2);
`endif
         s0 = rsp_sum;
         i0 = rsp_id;
         unstable = 0;
         for (int c = 0; c < 5; c++) begin
            @(posedge clk); #3;
            if (!rsp_vld || rsp_sum !== s0 || rsp_id !== i0) unstable++;
         end
         chk($sformatf("cont%0d_stable", j), unstable, 0);
         rsp_rdy = 1'b1;
         @(posedge clk); #2;
         rsp_rdy = 1'b0;
      end
      req_vld = '0;
      rsp_rdy = 1'b1;
      @(posedge clk); #2;

      // Reset after four bits of a job.
      req_a[7:0] = 8'h55;
      req_b[7:0] = 8'h0A;
      req_vld = 2'b01;
      @(posedge clk); #2;
      req_vld = '0;
      seen = 0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         if (rsp_vld) seen++;
         @(posedge clk); #2;
      end
      req_vld = 2'b01;
      #1;
      rst = 1'b1;
      #1;
      chk("arst_ser_vld", {31'd0, ser_vld}, 0);
      chk("arst_ser_last", {31'd0, ser_last}, 0);
      chk("arst_req_rdy", {30'd0, req_rdy}, 0);
      chk("arst_rsp_vld", {31'd0, rsp_vld}, 0);
      chk("arst_rsp_sum", {24'd0, rsp_sum}, 0);
      chk("arst_rsp_id", {31'd0, rsp_id}, 0);
      @(posedge clk); #2;
      req_vld = '0;
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (rsp_vld) seen++;
         @(posedge clk); #2;
      end
      chk("arst_no_partial", seen, 0);
      job(0, 8'h03, 8'h04, 0, lat, nv, lastc, hv, rx);
      chk("arst_new_latency", lat, 9);
      chk("arst_new_sum", {24'd0, rsp_sum}, 32'h07);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
- Shares one external LSB-first serial adder between N_REQ parallel-operand requesters.
- Arbitrates among pending requests and latches the granted pair of W-bit operands.
- Drives the adder's vld/a/b/last pins one bit per cycle, collects the returned sum bits into a W-bit result, and presents it with the requester ID on a valid/ready response port.
- Sits between the requester blocks and the serial adder; it sequences the adder and holds no arithmetic of its own.

Parameters:
- N_REQ, 2: number of requesters, minimum 2.
- W, 8: operand and result width in bits, minimum 2.
- ID_W, $clog2(N_REQ): width of the response ID field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_vld  input  N_REQ  per-requester request valid.
- req_rdy  output  N_REQ  per-requester accept; at most one bit set.
- req_a  input  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  input  N_REQ*W  operand B, same packing as req_a.
- rsp_vld  output  1  result valid.
- rsp_rdy  input  1  result accepted by the consumer.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  W  (A+B) mod 2^W.
- ser_hold  input  1  pauses bit issue; while high, ser_vld is 0.
- ser_vld  output  1  to adder vld.
- ser_a  output  1  to adder a.
- ser_b  output  1  to adder b.
- ser_last  output  1  to adder last.
- ser_sum  input  1  from adder sum; combinational from ser_a/ser_b in the same cycle.

Behaviour:
- Reset (asynchronous, active-high) values: state IDLE; bit counter 0; rsp_vld 0; rsp_id 0; rsp_sum 0; req_rdy 0; ser_vld, ser_a, ser_b and ser_last all 0; arbitration pointer 0.
- The adder shares rst, so a reset in mid-operation aborts the transfer and clears the adder carry. No partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If any req_vld is set, assert req_rdy for exactly one requester g, chosen by the arbitration rule.
  - In the same cycle, latch req_a[g], req_b[g] and g, clear the bit counter, and go to SHIFT.
  - req_rdy is 0 in every other state.
  - Arbitration rule: fixed priority, lowest index wins, unless SADD_RR_EN is defined.
- SHIFT, cycles where ser_hold is 0:
  - ser_vld=1; ser_a=A[cnt]; ser_b=B[cnt]; ser_last=(cnt==W-1).
  - Capture ser_sum into result bit cnt, then increment cnt.
  - When cnt==W-1 is issued, go to DONE.
- SHIFT, cycles where ser_hold is 1:
  - ser_vld=0, ser_last=0; cnt and the captured bits are frozen.
  - ser_a and ser_b are don't-care but driven 0.
- DONE:
  - rsp_vld=1; rsp_sum and rsp_id are stable until rsp_rdy is seen.
  - On rsp_vld&rsp_rdy, go to IDLE.
  - A new grant therefore occurs at the earliest one cycle later, giving one bubble between jobs.
- Latency with no hold: grant in cycle t; bits issued in cycles t+1..t+W; rsp_vld first high in cycle t+W+1.
- Width: the final carry-out is discarded (the adder exposes no carry), so overflow wraps. The last pulse clears the adder carry for the next job.
- Boundary cases:
  - A requester that deasserts req_vld while not granted is simply skipped.
  - Operands are sampled only at the grant; later changes to req_a/req_b are ignored.
  - rsp_rdy held high while in DONE gives the minimum one-cycle response.
  - rsp_rdy asserted outside DONE has no effect.
  - ser_hold asserted in IDLE or DONE has no effect.
  - ser_hold asserted on the last-bit cycle delays ser_last until the next non-hold cycle.

Optional Feature:
- Macro: SADD_RR_EN.
- Defined: round-robin arbitration. The pointer moves to (g+1) mod N_REQ after each grant, and the search starts at the pointer, wrapping around. No requester waits more than N_REQ-1 jobs.
- Undefined: fixed priority, lowest index wins; the pointer register is not synthesized.

Test Plan:
- Single request, N_REQ=2, W=8, requester 0 with A=8'h35, B=8'h4A, ser_hold=0, rsp_rdy=1:
  - req_rdy[0] pulses once.
  - ser_vld is high for 8 cycles; ser_last is high on the 8th only.
  - rsp_vld appears 9 cycles after the grant with rsp_sum=8'h7F and rsp_id=0.
- Overflow: A=8'hFF, B=8'h01, then A=8'h02, B=8'h03 back-to-back:
  - First result rsp_sum=8'h00.
  - Second result rsp_sum=8'h05, proving the carry is cleared by last.
- Hold: ser_hold high for 3 cycles in the middle of SHIFT with A=8'h0F, B=8'h01:
  - ser_vld is 0 during the hold.
  - rsp_sum=8'h10; the response arrives 3 cycles later than in the no-hold case.
- Contention: both requesters assert continuously (r0: 1+1, r1: 2+2); rsp_rdy held low 5 cycles in DONE.
  - rsp_vld, rsp_sum and rsp_id stay stable while rsp_rdy is low.
  - Without SADD_RR_EN: results are all id 0.
  - With SADD_RR_EN: ids alternate 0,1,0,1 with sums 2,4,2,4.
- Reset mid-SHIFT after 4 bits, then a new job 3+4:
  - rsp_vld never goes high for the aborted job.
  - All outputs return to 0 immediately, without waiting for a clock edge.
  - The new job yields rsp_sum=8'h07.
